// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: bundles both masters' request/ack ports and the DRAM-side
// strobe bus into one interface.
// The "master" modport is everything around the arbiter: CPU, loader and
// memory. The "slave" modport is the arbiter itself.
interface dram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;
  logic          m0_stall;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_rdata, m0_stall,
    input  m1_ack, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_rdata, m0_stall,
    output m1_ack, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the CPU data port
// (master 0) and a secondary requester (master 1). One transaction at a time
// walks through IDLE -> ACCESS -> DONE, so a request seen in IDLE gets its
// memory strobe one cycle later and its ack two cycles later.
// Build option: define ARB_FIXED_PRIO_EN to make master 0 win every tie
// (master 1 may starve); by default ties alternate round-robin.
module dram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic           clk,
  input logic           rst,
  dram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state_q;
  logic          gnt_q;
  logic          we_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority keeps no grant history.
`else
  logic          last_gnt_q;
`endif

  logic          gnt_d;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Pick the winner among the current requests and mux its transaction fields.
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    gnt_d = ~bus.m0_req;
`else
    if (bus.m0_req && bus.m1_req) begin
      gnt_d = ~last_gnt_q;
    end else begin
      gnt_d = ~bus.m0_req;
    end
`endif
    sel_we    = gnt_d ? bus.m1_we    : bus.m0_we;
    sel_addr  = gnt_d ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = gnt_d ? bus.m1_wdata : bus.m0_wdata;
  end

  // Transaction sequencer: latch the winner in IDLE, strobe memory in ACCESS,
  // ack the winner in DONE. Strobes and acks are single-cycle registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef ARB_FIXED_PRIO_EN
`else
      last_gnt_q <= 1'b1;
`endif
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            gnt_q      <= gnt_d;
            we_q       <= sel_we;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            mem_en_q   <= 1'b1;
            mem_we_q   <= sel_we;
`ifdef ARB_FIXED_PRIO_EN
`else
            last_gnt_q <= gnt_d;
`endif
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory side: address and data hold their latched values between accesses.
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // Master side: read data is only forwarded to the acked master on a read.
  assign bus.m0_ack   = ack0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m0_rdata = (ack0_q && !we_q) ? bus.mem_rdata : '0;
  assign bus.m1_rdata = (ack1_q && !we_q) ? bus.mem_rdata : '0;
  assign bus.m0_stall = bus.m0_req & ~ack0_q;

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-master arbiter sharing the single-port data RAM between the CPU data port (master 0) and a secondary requester such as a program loader or debug port (master 1). It sits between the CPU/loader and the DRAM, and sequences one memory transaction at a time through a three-state FSM. It produces a CPU stall so that the PC enable can be gated while a CPU access is pending.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- m0_req / m1_req  in  1  request; held high until the matching ack
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req is high
- m0_addr / m1_addr  in  AW  byte address; stable while req is high
- m0_wdata / m1_wdata  in  DW  write data; stable while req is high
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DW  read data, valid only while ack is high on a read
- m0_stall  out  1  m0_req & ~m0_ack (combinational)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid the cycle after mem_en with mem_we=0

## Operation
- States: IDLE, ACCESS, DONE. The reset state is IDLE.
- IDLE: if any req is high, pick a winner, latch its we/addr/wdata into registers, store the grant index, and go to ACCESS. If no req is high, stay in IDLE.
- Arbitration:
  - If only one request is present, that master wins.
  - If both are present, the winner is the master ≠ last_gnt.
  - last_gnt is updated at each grant and reset to 1, so master 0 wins the first tie.
- ACCESS: mem_en=1; mem_we/mem_addr/mem_wdata come from the latched registers. Always go to DONE.
- DONE: the granted master's ack=1. On a read, its rdata = mem_rdata; otherwise rdata = 0. Always go to IDLE.
- The non-granted master's ack and rdata are 0 at all times.
- Requests arriving during ACCESS or DONE wait; they are evaluated in the next IDLE.
- A requester drops req (or re-asserts it for a new transaction) after seeing ack. A req that stays high in IDLE is treated as a new transaction.
- Outputs outside ACCESS: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their latched values.
- No address decoding: device-mapped addresses pass through unchanged.

## Timing
- Reset values: state=IDLE, last_gnt=1. mem_en, mem_we, mem_addr, mem_wdata, both acks and both rdata are all 0. m0_stall follows m0_req.
- Latency: req first seen high in IDLE cycle T, then mem_en in T+1, then ack in T+2.
- Throughput: one transaction per 3 cycles.
- Both masters request continuously: each master gets one transaction per 6 cycles.
- Simultaneous new requests in the same IDLE cycle are resolved by the arbitration rule; acks are never concurrent.
- Reset mid-transaction: rst forces IDLE immediately and mem_en/acks low. The in-flight transaction is abandoned and no ack is issued.
  - If rst hits in ACCESS before the clock edge, no write is committed.
  - The requester must re-issue after reset.

## Configuration
- ARB_FIXED_PRIO_EN:
  - Defined: master 0 always wins ties, and last_gnt is neither used nor updated. Master 1 can starve while master 0 requests continuously.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: assert rst with both reqs high. While rst is high, all outputs are 0 except m0_stall=1. After release, the first grant goes to master 0.
- Single read: m0 reads 0x10 with the memory model holding 0xDEADBEEF.
  - T+1: mem_en=1, mem_we=0, mem_addr=0x10.
  - T+2: m0_ack=1, m0_rdata=0xDEADBEEF, m1_ack=0.
- Write then read: m1 writes 0x55AA to 0x20, then m0 reads 0x20. The read returns 0x000055AA; mem_we=1 only in m1's ACCESS cycle.
- Contention: both reqs held for 4 transactions.
  - Default: grant order 0,1,0,1, with acks at cycles 2,5,8,11.
  - With ARB_FIXED_PRIO_EN: order 0,0,0,0 and m1_ack never asserts.
- Late arrival: m1_req rises during m0's ACCESS. m0 is acked first; m1 gets mem_en 2 cycles after m0_ack.
- Reset in ACCESS: a write to 0x30 is cut by rst. No ack is issued and memory at 0x30 is unchanged. A re-issued request completes with normal 2-cycle latency.
